// File: rtl/countdown_timer.sv
// ============================================================================
// Module  : countdown_timer
// Brief   : Cascaded mixed-radix down counter with run/pause/done control.
// Revision: 1.0 - initial multi-stage release
// ============================================================================
`default_nettype none

module countdown_timer #(
  parameter int NUM_STAGES  = 2,
  parameter int STAGE_WIDTH = 6,
  parameter int STAGE_TOP   = 59,
  parameter int WARN_LEVEL  = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tick,
  input  logic                              load,
  input  logic [NUM_STAGES*STAGE_WIDTH-1:0] load_val,
  input  logic                              start,
  input  logic                              pause,
  input  logic                              clear,
  output logic [NUM_STAGES*STAGE_WIDTH-1:0] count,
  output logic [1:0]                        state,
  output logic [NUM_STAGES-1:0]             stage_borrow,
  output logic                              done,
  output logic                              expired,
  output logic                              warn
);

  localparam int                     c_w    = NUM_STAGES * STAGE_WIDTH;
  localparam logic [STAGE_WIDTH-1:0] c_top  = STAGE_WIDTH'(STAGE_TOP);
  localparam logic [c_w-1:0]         c_warn = c_w'(WARN_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t                r_state;
  logic [c_w-1:0]        r_count;
  logic [NUM_STAGES-1:0] r_borrow;
  logic                  r_done;

  logic [c_w-1:0]        w_dec;
  logic [c_w-1:0]        w_sat;
  logic [NUM_STAGES-1:0] w_bin;
  logic [NUM_STAGES-1:0] w_wrap;
  logic                  w_term;

  assign w_bin[0] = 1'b1;

  // Borrow ripples upward only through stages sitting at zero.
  genvar i;
  generate
    for (i = 0; i < NUM_STAGES; i++) begin : g_stage
      logic [STAGE_WIDTH-1:0] w_digit;
      logic [STAGE_WIDTH-1:0] w_ld_digit;

      assign w_digit    = r_count[i*STAGE_WIDTH +: STAGE_WIDTH];
      assign w_ld_digit = load_val[i*STAGE_WIDTH +: STAGE_WIDTH];
      assign w_wrap[i]  = w_bin[i] && (w_digit == '0);

      assign w_dec[i*STAGE_WIDTH +: STAGE_WIDTH] =
        !w_bin[i]          ? w_digit :
        (w_digit == '0)    ? c_top   : w_digit - 1'b1;

      assign w_sat[i*STAGE_WIDTH +: STAGE_WIDTH] =
        (w_ld_digit > c_top) ? c_top : w_ld_digit;

      if (i < NUM_STAGES - 1) begin : g_chain
        assign w_bin[i+1] = w_wrap[i];
      end
    end
  endgenerate

  // A zero count in RUN is also terminal so the top stage can never wrap.
  assign w_term = (w_dec == '0) || (r_count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_borrow <= '0;
      r_done   <= 1'b0;
    end else begin
      r_borrow <= '0;
      r_done   <= 1'b0;
      if (clear) begin
        r_count <= '0;
        r_state <= S_IDLE;
      end else if (load) begin
        r_count <= w_sat;
        r_state <= S_IDLE;
      end else if (start && (r_state == S_IDLE || r_state == S_PAUSE)) begin
        if (r_count == '0) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_RUN;
        end
      end else if (pause && r_state == S_RUN) begin
        r_state <= S_PAUSE;
      end else if (tick && r_state == S_RUN) begin
        if (w_term) begin
          r_count <= '0;
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_count  <= w_dec;
          r_borrow <= w_wrap;
        end
      end
    end
  end

  assign count        = r_count;
  assign state        = r_state;
  assign stage_borrow = r_borrow;
  assign done         = r_done;
  assign expired      = (r_state == S_DONE);
  assign warn         = (r_state == S_RUN) && (r_count <= c_warn);

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module  : tb_countdown_timer
// Brief   : Directed self-checking bench for the two-stage sec:min timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        load;
  logic [11:0] load_val;
  logic        start;
  logic        pause;
  logic        clear;
  logic [11:0] count;
  logic [1:0]  state;
  logic [1:0]  stage_borrow;
  logic        done;
  logic        expired;
  logic        warn;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] c_idle  = 2'b00;
  localparam logic [1:0] c_run   = 2'b01;
  localparam logic [1:0] c_pause = 2'b10;
  localparam logic [1:0] c_done  = 2'b11;

  countdown_timer #(
    .NUM_STAGES (2),
    .STAGE_WIDTH(6),
    .STAGE_TOP  (59),
    .WARN_LEVEL (10)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .pause       (pause),
    .clear       (clear),
    .count       (count),
    .state       (state),
    .stage_borrow(stage_borrow),
    .done        (done),
    .expired     (expired),
    .warn        (warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input int mins, input int secs);
    logic [5:0] m;
    logic [5:0] s;
    m = 6'(mins);
    s = 6'(secs);
    return {m, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick  = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [11:0] v);
    load_val = v;
    load     = 1'b1;
    cyc();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    load_val = '0;
    idle_inputs();
    #12;
    check("rst_count", 32'(count), 32'h0);
    check("rst_state", 32'(state), 32'(c_idle));
    check("rst_flags", {27'd0, stage_borrow, done, expired, warn}, 32'h0);
    reset = 1'b1;
    cyc();

    // Asynchronous reset mid-RUN at 2:35
    do_load(pk(2, 35));
    check("t1_load", 32'(count), 32'h0A3);
    do_start();
    check("t1_run", 32'(state), 32'(c_run));
    #2;
    reset = 1'b0;
    #1;
    check("t1_async_count", 32'(count), 32'h0);
    check("t1_async_state", 32'(state), 32'(c_idle));
    check("t1_async_flags", {27'd0, stage_borrow, done, expired, warn}, 32'h0);
    cyc();
    reset = 1'b1;
    cyc();

    // Borrow from minutes into seconds
    do_load(pk(1, 0));
    do_start();
    do_tick();
    check("t2_count", 32'(count), 32'(pk(0, 59)));
    check("t2_borrow", 32'(stage_borrow), 32'h1);
    check("t2_state", 32'(state), 32'(c_run));
    check("t2_warn", 32'(warn), 32'h0);
    cyc();
    check("t2_borrow_clr", 32'(stage_borrow), 32'h0);

    // Back-to-back ticks with borrow on the second
    do_load(pk(1, 1));
    do_start();
    tick = 1'b1;
    cyc();
    check("bb_first", 32'(count), 32'(pk(1, 0)));
    check("bb_first_bor", 32'(stage_borrow), 32'h0);
    cyc();
    tick = 1'b0;
    check("bb_second", 32'(count), 32'(pk(0, 59)));
    check("bb_second_bor", 32'(stage_borrow), 32'h1);

    // Terminal count
    do_load(pk(0, 2));
    do_start();
    do_tick();
    check("t3_one", 32'(count), 32'(pk(0, 1)));
    check("t3_warn", 32'(warn), 32'h1);
    do_tick();
    check("t3_zero", 32'(count), 32'h0);
    check("t3_state", 32'(state), 32'(c_done));
    check("t3_done", 32'(done), 32'h1);
    check("t3_expired", 32'(expired), 32'h1);
    check("t3_warn_off", 32'(warn), 32'h0);
    do_tick();
    check("t3_done_pulse", 32'(done), 32'h0);
    check("t3_hold", 32'(count), 32'h0);
    check("t3_exp_hold", 32'(expired), 32'h1);
    do_start();
    check("t3_start_ign", {30'd0, state}, 32'(c_done));
    check("t3_no_redone", 32'(done), 32'h0);

    // Pause drops a simultaneous tick
    do_load(pk(0, 30));
    do_start();
    pause = 1'b1;
    tick  = 1'b1;
    cyc();
    idle_inputs();
    check("t4_count", 32'(count), 32'(pk(0, 30)));
    check("t4_state", 32'(state), 32'(c_pause));
    do_tick();
    check("t4_pause_tick", 32'(count), 32'(pk(0, 30)));
    do_start();
    do_tick();
    check("t4_resume", 32'(count), 32'(pk(0, 29)));

    // Saturating load, then load overriding tick while running
    do_load({6'd5, 6'd63});
    check("t5_sat", 32'(count), 32'(pk(5, 59)));
    do_start();
    do_tick();
    check("t5_dec", 32'(count), 32'(pk(5, 58)));
    load_val = pk(3, 3);
    load     = 1'b1;
    tick     = 1'b1;
    cyc();
    idle_inputs();
    check("t5_ld_tick", 32'(count), 32'(pk(3, 3)));
    check("t5_ld_state", 32'(state), 32'(c_idle));

    // Warn threshold, pause, clear and start from zero
    do_load(pk(0, 11));
    do_start();
    check("t6_warn_11", 32'(warn), 32'h0);
    do_tick();
    check("t6_count_10", 32'(count), 32'(pk(0, 10)));
    check("t6_warn_10", 32'(warn), 32'h1);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    check("t6_warn_pause", 32'(warn), 32'h0);
    clear = 1'b1;
    start = 1'b1;
    cyc();
    idle_inputs();
    check("t6_clear_cnt", 32'(count), 32'h0);
    check("t6_clear_st", 32'(state), 32'(c_idle));
    do_start();
    check("t6_zero_start", 32'(state), 32'(c_done));
    check("t6_zero_done", 32'(done), 32'h1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("t6_final_st", 32'(state), 32'(c_idle));
    check("t6_final_exp", 32'(expired), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Parametrised multi-stage down-counting timer, successor to the single-stage minute/second counter. Cascades NUM_STAGES mixed-radix stages, such as sec:min or sec:min:hr, each counting STAGE_TOP..0 with borrow into the next stage. Adds a run/pause/done state machine, a tick enable, synchronous load, saturation of illegal load digits, a terminal-count done pulse and a warning level. Sits between the 1 Hz tick generator and the display/alarm logic of the egg timer.

Parameters:
NUM_STAGES, 2, number of cascaded stages; stage 0 is least significant.
STAGE_WIDTH, 6, bits per stage.
STAGE_TOP, 59, per-stage maximum; a stage wraps 0 -> STAGE_TOP on borrow.
WARN_LEVEL, 10, packed count value (stage 0 in LSBs) at or below which warn asserts while RUN.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
tick  in  1  one-cycle count enable, e.g. 1 Hz strobe.
load  in  1  synchronous load of load_val.
load_val  in  NUM_STAGES*STAGE_WIDTH  packed start value; stage i is bits [i*STAGE_WIDTH +: STAGE_WIDTH].
start  in  1  begin or resume counting.
pause  in  1  suspend counting.
clear  in  1  synchronous zero of count and return to IDLE.
count  out  NUM_STAGES*STAGE_WIDTH  current packed value.
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
stage_borrow  out  NUM_STAGES  one-cycle pulse per stage that wrapped 0 -> STAGE_TOP this cycle.
done  out  1  one-cycle pulse on entering DONE.
expired  out  1  level, high while in DONE.
warn  out  1  level, high when state==RUN and count <= WARN_LEVEL.

Behaviour:
- Reset (reset low, asynchronous): count=0, state=IDLE, stage_borrow=0, done=0, expired=0, warn=0. Release is sampled synchronously; the first update occurs on the first clk edge with reset high.
- Input priority per cycle: clear > load > start > pause > tick.
- clear (any state): count=0, state->IDLE. All other inputs in that cycle are ignored.
- load: allowed in every state.
  - Each stage is loaded with min(digit, STAGE_TOP); illegal digits saturate.
  - state->IDLE, including when in RUN (load aborts the run).
  - A simultaneous tick is dropped.
- start:
  - IDLE or PAUSE with count!=0 -> RUN.
  - IDLE or PAUSE with count==0 -> DONE, with a done pulse.
  - Ignored in RUN and DONE.
- pause: RUN -> PAUSE; ignored in other states. A tick in the same cycle is dropped.
- tick in RUN: the count decrements by one mixed-radix unit on that edge.
  - Stage 0 decrements. A stage at 0 wraps to STAGE_TOP, pulses its stage_borrow bit and borrows from stage i+1.
  - A stage at STAGE_TOP is left unchanged unless borrowed into.
- Terminal count: if a tick takes count to 0, then on the same edge count=0, state->DONE, and done pulses high for exactly the following cycle. No further decrement; count holds 0.
- tick is ignored in IDLE, PAUSE and DONE.
- The top stage never wraps: reaching all-zero ends the run first.
- DONE is left only via load or clear.
- Latency: count, state and flags are registered and update one edge after the qualifying input. warn and expired are decoded from registered state/count, with no extra cycle.
- warn comparison: unsigned on the full packed vector. This is valid because each digit is <= STAGE_TOP, so packed order equals time order.
- Back-to-back ticks on consecutive cycles must each decrement.
- stage_borrow bits and done are 0 in every cycle without the triggering event.

Test Plan:
1. Reset low mid-RUN with count=0x0A3 (2:35) -> count=0, state=IDLE, all flags 0 immediately, before the next clk edge.
2. Load {min=1,sec=0}, start, one tick -> count {0,59}; stage_borrow=01 for one cycle; state RUN.
3. Load {0,2}, start, two ticks -> after the 2nd tick count=0, state=DONE, done high exactly one cycle, expired stays high.
4. RUN at {0,30}: pause with tick in the same cycle -> count stays {0,30}, state PAUSE; then start, tick -> {0,29}.
5. Load {5,63} (illegal digit) -> count {5,59}. Load and tick in the same cycle while RUN -> loaded value, state IDLE, no decrement.
6. Load {0,11}, start, tick -> warn rises when count reaches {0,10}; warn drops when paused. Start with count 0 -> DONE plus done pulse; clear -> IDLE, count 0.
